fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit processor.
- Owns the program counter and drives the byte address into the 128-entry instruction memory (combinational read of word ADDR[7:1]).
- Registers the returned word into the IF/ID pipeline register for the decoder.
- Handles branch redirect from execute, pipeline stall, and halt on the all-zero fill word that follows every program image.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_pc_reg.sv | 27 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the decoder: FSM encoding,
// default widths, the halt encoding and the major opcodes.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam logic [DATA_W_DEF-1:0] HALT_WORD_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [3:0] OP_RTYPE = 4'b1111;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_LB    = 4'b0010;
    localparam logic [3:0] OP_SB    = 4'b0100;
    localparam logic [3:0] OP_ANDI  = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_BGEZ  = 4'b1010;
    localparam logic [3:0] OP_BLTZ  = 4'b1011;

    function automatic logic [3:0] opcode_of(input logic [DATA_W_DEF-1:0] instr);
        return instr[DATA_W_DEF-1 -: 4];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory, hazard/branch controls and IF/ID outputs.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [DATA_W-1:0] IMEM_Q;
    logic              STALL;
    logic              BR_TAKEN;
    logic [ADDR_W-1:0] BR_TARGET;
    logic [DATA_W-1:0] IR_OUT;
    logic [ADDR_W-1:0] PC_OUT;
    logic              VALID_OUT;
    logic              HALTED;

    modport master (
        output IMEM_ADDR, IR_OUT, PC_OUT, VALID_OUT, HALTED,
        input  IMEM_Q, STALL, BR_TAKEN, BR_TARGET
    );

    modport slave (
        input  IMEM_ADDR, IR_OUT, PC_OUT, VALID_OUT, HALTED,
        output IMEM_Q, STALL, BR_TAKEN, BR_TARGET
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC select: redirect beats increment beats hold.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              pc_inc,
    input  logic              pc_redir,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(1);

    // Increment wraps modulo 2^ADDR_W; targets are forced halfword aligned.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            pc <= RESET_PC & ALIGN;
        else if (pc_redir)
            pc <= pc_target & ALIGN;
        else if (pc_inc)
            pc <= pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IF/ID register, and the BOOT/RUN/HALT sequencer.
//   state | meaning
//   BOOT  | one idle cycle after reset while the instruction memory loads
//   RUN   | fetching one word per cycle, honouring redirect and stall
//   HALT  | stopped on the halt word; only a redirect restarts fetch
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_unit_if.master  bus
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] link_pc;
    logic              valid, halted;
    logic              pc_inc, pc_redir, ld_ir, clr_valid, set_halt, clr_halt;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .CLK       (CLK),
        .RESET     (RESET),
        .pc_inc    (pc_inc),
        .pc_redir  (pc_redir),
        .pc_target (bus.BR_TARGET),
        .pc        (pc)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= ST_BOOT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pc_inc    = 1'b0;
        pc_redir  = 1'b0;
        ld_ir     = 1'b0;
        clr_valid = 1'b0;
        set_halt  = 1'b0;
        clr_halt  = 1'b0;
        unique case (state)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN: begin
                if (bus.BR_TAKEN) begin
                    pc_redir  = 1'b1;
                    clr_valid = 1'b1;
                end else if (bus.STALL) begin
                    state_n = ST_RUN;
                end else if (bus.IMEM_Q == HALT_WORD) begin
                    clr_valid = 1'b1;
                    set_halt  = 1'b1;
                    state_n   = ST_HALT;
                end else begin
                    ld_ir  = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.BR_TAKEN) begin
                    pc_redir = 1'b1;
                    clr_halt = 1'b1;
                    state_n  = ST_RUN;
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ir      <= '0;
            link_pc <= '0;
            valid   <= 1'b0;
            halted  <= 1'b0;
        end else begin
            if (ld_ir) begin
                ir      <= bus.IMEM_Q;
                link_pc <= pc + ADDR_W'(2);
                valid   <= 1'b1;
            end else if (clr_valid) begin
                valid   <= 1'b0;
            end
            if (set_halt)
                halted <= 1'b1;
            else if (clr_halt)
                halted <= 1'b0;
        end
    end

    assign bus.IMEM_ADDR = pc;
    assign bus.IR_OUT    = ir;
    assign bus.PC_OUT    = link_pc;
    assign bus.VALID_OUT = valid;
    assign bus.HALTED    = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected IF/ID words,
// a negedge monitor pops and compares whenever VALID_OUT is high.
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [128];
    assign bus.IMEM_Q = mem[bus.IMEM_ADDR[7:1]];

    typedef struct packed {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Memory image: real code at 0,2,4, filler words elsewhere, halt word at 0x7E.
    function automatic logic [15:0] word_at(input logic [7:0] a);
        logic [6:0] w;
        w = a[7:1];
        if (w == 7'd0)  return 16'hF001;
        if (w == 7'd1)  return 16'hF491;
        if (w == 7'd2)  return 16'hFFF9;
        if (w == 7'd63) return 16'h0000;
        return 16'hA000 | {9'd0, w};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [15:0] ir, input logic [7:0] pc);
        exp_q.push_back({ir, pc});
    endtask

    // Free-running issues from start: word at a appears with link pc a+2.
    task automatic run_issue(input logic [7:0] start, input int n);
        logic [7:0] a;
        a = start;
        for (int k = 0; k < n; k++) begin
            tick();
            push(word_at(a), a + 8'd2);
            a = a + 8'd2;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.VALID_OUT === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", {bus.IR_OUT, bus.PC_OUT}, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ir_out", {16'd0, bus.IR_OUT}, {16'd0, e.ir});
                    chk("pc_out", {24'd0, bus.PC_OUT}, {24'd0, e.pc});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] a0;
        for (int i = 0; i < 128; i++) begin
            a0 = 8'(i * 2);
            mem[i] = word_at(a0);
        end
        bus.STALL     = 1'b0;
        bus.BR_TAKEN  = 1'b0;
        bus.BR_TARGET = 8'h00;

        #12;
        chk("rst_addr",   {24'd0, bus.IMEM_ADDR}, 32'h00);
        chk("rst_ir",     {16'd0, bus.IR_OUT}, 32'h0);
        chk("rst_pcout",  {24'd0, bus.PC_OUT}, 32'h0);
        chk("rst_valid",  {31'd0, bus.VALID_OUT}, 32'd0);
        chk("rst_halted", {31'd0, bus.HALTED}, 32'd0);
        RESET = 1'b1;

        tick();
        chk("boot_valid", {31'd0, bus.VALID_OUT}, 32'd0);
        chk("boot_addr",  {24'd0, bus.IMEM_ADDR}, 32'h00);

        tick(); push(16'hF001, 8'h02);
        tick(); push(16'hF491, 8'h04);

        bus.STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            push(16'hF491, 8'h04);
            chk("stall_addr", {24'd0, bus.IMEM_ADDR}, 32'h04);
        end
        bus.STALL = 1'b0;
        tick(); push(16'hFFF9, 8'h06);

        run_issue(8'h06, 13);
        chk("pre_br_addr", {24'd0, bus.IMEM_ADDR}, 32'h20);

        bus.BR_TAKEN = 1'b1; bus.BR_TARGET = 8'h21; bus.STALL = 1'b1;
        tick();
        chk("br_addr",  {24'd0, bus.IMEM_ADDR}, 32'h20);
        chk("br_valid", {31'd0, bus.VALID_OUT}, 32'd0);
        bus.BR_TAKEN = 1'b0; bus.STALL = 1'b0;
        tick(); push(16'hA010, 8'h22);

        run_issue(8'h22, 46);
        chk("pre_halt_addr", {24'd0, bus.IMEM_ADDR}, 32'h7E);
        tick();
        chk("halt_valid",  {31'd0, bus.VALID_OUT}, 32'd0);
        chk("halt_flag",   {31'd0, bus.HALTED}, 32'd1);
        chk("halt_addr",   {24'd0, bus.IMEM_ADDR}, 32'h7E);
        bus.STALL = 1'b1;
        tick(); tick();
        chk("halt_hold_flag", {31'd0, bus.HALTED}, 32'd1);
        chk("halt_hold_addr", {24'd0, bus.IMEM_ADDR}, 32'h7E);
        bus.STALL = 1'b0;

        bus.BR_TAKEN = 1'b1; bus.BR_TARGET = 8'h0C;
        tick();
        chk("unhalt_flag", {31'd0, bus.HALTED}, 32'd0);
        chk("unhalt_addr", {24'd0, bus.IMEM_ADDR}, 32'h0C);
        chk("unhalt_valid", {31'd0, bus.VALID_OUT}, 32'd0);
        bus.BR_TAKEN = 1'b0;
        tick(); push(16'hA006, 8'h0E);

        // Redirect onto the halt word, then redirect again while it is presented.
        bus.BR_TAKEN = 1'b1; bus.BR_TARGET = 8'h7E;
        tick();
        chk("to_halt_word_addr", {24'd0, bus.IMEM_ADDR}, 32'h7E);
        bus.BR_TARGET = 8'hFC;
        tick();
        chk("br_beats_halt_flag", {31'd0, bus.HALTED}, 32'd0);
        chk("br_beats_halt_addr", {24'd0, bus.IMEM_ADDR}, 32'hFC);
        bus.BR_TAKEN = 1'b0;
        tick(); push(16'hA07E, 8'hFE);
        tick(); push(16'hA07F, 8'h00);
        chk("wrap_addr", {24'd0, bus.IMEM_ADDR}, 32'h00);
        tick(); push(16'hF001, 8'h02);

        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_addr",   {24'd0, bus.IMEM_ADDR}, 32'h00);
        chk("async_ir",     {16'd0, bus.IR_OUT}, 32'h0);
        chk("async_pcout",  {24'd0, bus.PC_OUT}, 32'h0);
        chk("async_valid",  {31'd0, bus.VALID_OUT}, 32'd0);
        chk("async_halted", {31'd0, bus.HALTED}, 32'd0);
        #1;
        RESET = 1'b1;
        tick();
        chk("reboot_valid", {31'd0, bus.VALID_OUT}, 32'd0);
        tick(); push(16'hF001, 8'h02);

        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
